// File: rtl/div_mon_pkg.sv
// Shared types, default parameters and helpers for the divided-clock monitor.
package div_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCKED
    } mon_state_t;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_EXP_PERIOD = 7;
    localparam int DEF_HIGH_MIN   = 3;
    localparam int DEF_HIGH_MAX   = 4;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int DEF_TIMEOUT    = 14;

    // Increment that sticks at limit instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
        return (value >= limit) ? limit : value + 32'd1;
    endfunction

endpackage

// File: rtl/div_mon_edge_det.sv
// Two-stage sampler of the divided clock producing rise/fall strobes and the sampled level.
module div_mon_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic level
);

    logic d1;
    logic d2;

    // Delay line: d1 is the sampled input, d2 is d1 one cycle older.
    always_ff @(posedge clk) begin
        if (rst) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            // NOTE: non-blocking so d2 picks up the previous d1, not the one written this edge.
            d1 <= din;
            d2 <= d1;
        end
    end

    assign rise  = d1 & ~d2;
    assign fall  = ~d1 & d2;
    assign level = d1;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures period and high time of a divided clock, tracks lock and raises sticky errors.
module div_clk_monitor
    import div_mon_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int HIGH_MIN   = DEF_HIGH_MIN,
    parameter int HIGH_MAX   = DEF_HIGH_MAX,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_clk_in,
    input  logic             clear_err,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             err_period,
    output logic             err_high,
    output logic             stuck,
    output logic [7:0]       err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int               GOOD_W  = $clog2(LOCK_COUNT + 1);

    logic             rise;
    logic             fall;
    logic             level;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] high_lat;
    mon_state_t       state;
    mon_state_t       state_next;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_cnt_next;
    logic             meas_now;
    logic             period_ok;
    logic             high_ok;
    logic             good;
    logic             timeout;

    div_mon_edge_det u_edge (
        .clk   (clk),
        .rst   (rst),
        .din   (div_clk_in),
        .rise  (rise),
        .fall  (fall),
        .level (level)
    );

    // A rise only closes a measurement once an earlier rise has opened one.
    assign meas_now  = rise && (state != IDLE);
    assign period_ok = (period_cnt == CNT_W'(EXP_PERIOD));
    assign high_ok   = (high_lat >= CNT_W'(HIGH_MIN)) && (high_lat <= CNT_W'(HIGH_MAX));
    assign good      = period_ok && high_ok;
    // period_cnt passes TIMEOUT only once per gap, so this strobes a single cycle.
    assign timeout   = !rise && (period_cnt == CNT_W'(TIMEOUT));
    assign locked    = (state == LOCKED);

    // Period and high-time counters; high time is latched on the falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            high_lat   <= '0;
        end else begin
            if (rise) period_cnt <= CNT_W'(1);
            else      period_cnt <= CNT_W'(sat_inc(32'(period_cnt), 32'(CNT_MAX)));

            if (rise)       high_cnt <= CNT_W'(1);
            else if (level) high_cnt <= CNT_W'(sat_inc(32'(high_cnt), 32'(CNT_MAX)));

            if (fall) high_lat <= high_cnt;
        end
    end

    // Measurement outputs, updated on every rise that completes a period.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= meas_now;
            if (meas_now) begin
                period_out <= period_cnt;
                high_out   <= high_lat;
            end
        end
    end

    // Lock FSM state and good-period run length.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            good_cnt <= '0;
        end else begin
            state    <= state_next;
            good_cnt <= good_cnt_next;
        end
    end

    // Lock FSM transitions: a timeout overrides everything and returns to IDLE.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        state_next    = state;
        good_cnt_next = good_cnt;
        if (timeout) begin
            state_next    = IDLE;
            good_cnt_next = '0;
        end else if (rise) begin
            case (state)
                IDLE: begin
                    state_next    = ACQ;
                    good_cnt_next = '0;
                end
                ACQ: begin
                    if (!good) begin
                        good_cnt_next = '0;
                    end else if (good_cnt + GOOD_W'(1) == GOOD_W'(LOCK_COUNT)) begin
                        state_next    = LOCKED;
                        good_cnt_next = '0;
                    end else begin
                        good_cnt_next = good_cnt + GOOD_W'(1);
                    end
                end
                LOCKED: begin
                    if (!good) begin
                        state_next    = ACQ;
                        good_cnt_next = '0;
                    end
                end
                default: begin
                    state_next    = IDLE;
                    good_cnt_next = '0;
                end
            endcase
        end
    end

    // Sticky error flags and count; a new error in the clear cycle overrides the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_period <= 1'b0;
            err_high   <= 1'b0;
            stuck      <= 1'b0;
            err_count  <= '0;
        end else begin
            if (clear_err) begin
                err_period <= 1'b0;
                err_high   <= 1'b0;
                stuck      <= 1'b0;
                err_count  <= '0;
            end
            if (meas_now && !good) begin
                if (!period_ok) err_period <= 1'b1;
                if (!high_ok)   err_high   <= 1'b1;
                err_count <= clear_err ? 8'd1 : 8'(sat_inc(32'(err_count), 32'd255));
            end
            if (timeout) stuck <= 1'b1;
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor with a measurement scoreboard.
module tb_div_clk_monitor;
    import div_mon_pkg::*;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 14;

    typedef struct {
        int period;
        int high;
    } meas_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             div_clk_in;
    logic             clear_err;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             meas_valid;
    logic             locked;
    logic             err_period;
    logic             err_high;
    logic             stuck;
    logic [7:0]       err_count;

    meas_t exp_q[$];
    int    n_asserts = 0;
    int    n_fails   = 0;
    int    last_h    = 0;
    int    last_p    = 0;
    bit    have_prev = 1'b0;

    always #5 clk = ~clk;

    div_clk_monitor #(
        .CNT_W      (CNT_W),
        .EXP_PERIOD (7),
        .HIGH_MIN   (3),
        .HIGH_MAX   (4),
        .LOCK_COUNT (4),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .div_clk_in (div_clk_in),
        .clear_err  (clear_err),
        .period_out (period_out),
        .high_out   (high_out),
        .meas_valid (meas_valid),
        .locked     (locked),
        .err_period (err_period),
        .err_high   (err_high),
        .stuck      (stuck),
        .err_count  (err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string step, input logic lk, input logic ep,
                                input logic eh, input logic st, input int cnt);
        check({step, "_locked"},     32'(locked),     32'(lk));
        check({step, "_err_period"}, 32'(err_period), 32'(ep));
        check({step, "_err_high"},   32'(err_high),   32'(eh));
        check({step, "_stuck"},      32'(stuck),      32'(st));
        check({step, "_err_count"},  32'(err_count),  32'(cnt));
    endtask

    // One divided-clock period: h cycles high then p-h low. The rise reports the
    // previous period if one was open; clr pulses clear_err in the reporting cycle.
    task automatic pulse(input int h, input int p, input bit clr);
        meas_t m;
        if (have_prev) begin
            m.period = last_p;
            m.high   = last_h;
            exp_q.push_back(m);
        end
        for (int i = 0; i < p; i++) begin
            div_clk_in = (i < h);
            clear_err  = clr && (i == 1);
            @(negedge clk);
        end
        clear_err = 1'b0;
        last_h    = h;
        last_p    = p;
        have_prev = (p <= TIMEOUT);
    endtask

    // Scoreboard: every meas_valid pulse must match the oldest expected measurement.
    always @(negedge clk) begin
        meas_t m;
        if (meas_valid === 1'b1) begin
            check("meas_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                m = exp_q.pop_front();
                check("meas_period", 32'(period_out), 32'(m.period));
                check("meas_high",   32'(high_out),   32'(m.high));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        div_clk_in = 1'b0;
        clear_err  = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_period_out", 32'(period_out), 32'd0);
        check("rst_high_out",   32'(high_out),   32'd0);
        check("rst_meas_valid", 32'(meas_valid), 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        #7 rst = 1'b0;
        @(negedge clk);

        // Acquire: first rise opens, four good measurements lock.
        pulse(4, 7, 1'b0);
        pulse(3, 7, 1'b0);
        pulse(4, 7, 1'b0);
        pulse(3, 7, 1'b0);
        check_status("acq3", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        pulse(4, 7, 1'b0);
        check_status("lock", 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // One 8-cycle period while locked, then relock.
        pulse(4, 8, 1'b0);
        check("long_still_locked", 32'(locked), 32'd1);
        pulse(4, 7, 1'b0);
        check_status("bad_period", 1'b0, 1'b1, 1'b0, 1'b0, 1);
        pulse(3, 7, 1'b0);
        pulse(4, 7, 1'b0);
        pulse(3, 7, 1'b0);
        check_status("relock3", 1'b0, 1'b1, 1'b0, 1'b0, 1);
        pulse(4, 7, 1'b0);
        check_status("relock", 1'b1, 1'b1, 1'b0, 1'b0, 1);

        // Plain clear alongside a good measurement.
        pulse(4, 7, 1'b1);
        check_status("clear", 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // High time 5 with correct period, twice.
        pulse(5, 7, 1'b0);
        pulse(5, 7, 1'b0);
        pulse(4, 7, 1'b0);
        check_status("bad_high", 1'b0, 1'b0, 1'b1, 1'b0, 2);

        // Clear in the same cycle as a new period error: the new error wins.
        pulse(4, 9, 1'b0);
        pulse(4, 7, 1'b1);
        check_status("clear_vs_err", 1'b0, 1'b1, 1'b0, 1'b0, 1);

        // Relock, then starve the monitor of rises.
        pulse(4, 7, 1'b0);
        pulse(3, 7, 1'b0);
        pulse(4, 7, 1'b0);
        pulse(4, 7, 1'b0);
        check("prestuck_locked", 32'(locked), 32'd1);
        pulse(4, 4 + TIMEOUT, 1'b0);
        check_status("stuck", 1'b0, 1'b1, 1'b0, 1'b1, 1);
        pulse(4, 7, 1'b0);
        pulse(3, 7, 1'b0);
        check("stuck_sticky", 32'(stuck), 32'd1);
        pulse(4, 7, 1'b1);
        check_status("clear_stuck", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        pulse(3, 7, 1'b0);
        pulse(4, 7, 1'b0);
        check("prereset_locked", 32'(locked), 32'd1);

        // Reset in the middle of a locked period.
        begin
            meas_t m;
            m.period = last_p;
            m.high   = last_h;
            exp_q.push_back(m);
        end
        div_clk_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_period_out", 32'(period_out), 32'd0);
        check("rst2_high_out",   32'(high_out),   32'd0);
        check("rst2_meas_valid", 32'(meas_valid), 32'd0);
        check_status("rst2", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        rst       = 1'b0;
        have_prev = 1'b0;

        // Remeasure from IDLE; input high right after reset counts as a rise.
        pulse(4, 7, 1'b0);
        pulse(3, 7, 1'b0);
        pulse(4, 7, 1'b0);
        pulse(3, 7, 1'b0);
        check("reacq_locked", 32'(locked), 32'd0);
        pulse(4, 7, 1'b0);
        check_status("reacq", 1'b1, 1'b0, 1'b0, 1'b0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
